data_mem_responder: RTL and testbench

//  Memory-side responder for the core's load/store port: accepts one request at a time over a

---
 rtl/data_mem_responder_if.sv | 24 ++
 rtl/data_mem_responder.sv | 248 ++++++++++++++++++++++++
 tb/tb_data_mem_responder.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/data_mem_responder_if.sv
// Load/store channel between the core (master) and the data memory responder (slave).
// Requests and responses are separate valid/ready channels.
interface data_mem_if;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        req_we;
  logic [1:0]  req_size;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_fault;

  modport master (
    output req_valid, req_addr, req_we, req_size, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_fault
  );

  modport slave (
    input  req_valid, req_addr, req_we, req_size, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_fault
  );
endinterface

// File: rtl/data_mem_responder.sv
// Data memory responder: a word-organised little-endian RAM behind a one-outstanding
// request/response channel. Accesses that straddle a word boundary are split into two
// consecutive word cycles (ACC0, ACC1). Window and size checks are resolved at accept
// time, so a faulting request never touches the RAM.
module data_mem_responder #(
  parameter logic [31:0] BASE_ADDR  = 32'h8000_0000,
  parameter int unsigned WORDS_LOG2 = 21
) (
  input  logic       clk,
  input  logic       rst_n,
  data_mem_if.slave  bus
);

  localparam int unsigned DEPTH     = 32'd1 << WORDS_LOG2;
  localparam logic [32:0] WIN_BYTES = 33'd1 << (WORDS_LOG2 + 32'd2);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC0 = 2'd1,
    ACC1 = 2'd2,
    RESP = 2'd3
  } state_e;

  // Backing store; contents are deliberately not reset.
  logic [31:0] ram_q [DEPTH];

  state_e state_q, state_d;

  // Captured request and response registers
  logic [WORDS_LOG2-1:0] idx_q, idx_d;
  logic [1:0]            off_q, off_d;
  logic [1:0]            size_q, size_d;
  logic                  we_q, we_d;
  logic                  split_q, split_d;
  logic [7:0]            mask_q, mask_d;
  logic [63:0]           wdata_q, wdata_d;
  logic [31:0]           lo_q, lo_d;
  logic [31:0]           rdata_q, rdata_d;
  logic                  fault_q, fault_d;

  // Request decode
  logic                  accept_s;
  logic [3:0]            nbytes_s;
  logic [32:0]           off33_s;
  logic [32:0]           end33_s;
  logic                  req_fault_s;
  logic                  req_split_s;
  logic [7:0]            byte_keep_s;
  logic [7:0]            lane_mask_s;
  logic [63:0]           wdata_shift_s;

  // RAM port
  logic [WORDS_LOG2-1:0] acc_idx_s;
  logic [31:0]           rd_word_s;
  logic                  wr_en_s;
  logic [3:0]            wr_be_s;
  logic [31:0]           wr_word_s;

  // Extract nbytes of load data starting at byte offset off from a two-word window.
  function automatic logic [31:0] assemble(input logic [63:0] pair,
                                           input logic [1:0]  off,
                                           input logic [1:0]  size);
    logic [31:0] shifted;
    logic [31:0] keep;
    shifted = 32'(pair >> {off, 3'b000});
    case (size)
      2'd0:    keep = 32'h0000_00FF;
      2'd1:    keep = 32'h0000_FFFF;
      2'd2:    keep = 32'hFFFF_FFFF;
      default: keep = 32'h0000_0000;
    endcase
    return shifted & keep;
  endfunction

  // Request decode: window check in 33 bits so an address near the top cannot wrap past it
  always_comb begin
    accept_s      = bus.req_valid && (state_q == IDLE);
    nbytes_s      = 4'd1 << bus.req_size;
    off33_s       = {1'b0, bus.req_addr} - {1'b0, BASE_ADDR};
    end33_s       = off33_s + {29'd0, nbytes_s};
    req_fault_s   = (bus.req_size == 2'd3) || (bus.req_addr < BASE_ADDR) || (end33_s > WIN_BYTES);
    req_split_s   = ({3'd0, bus.req_addr[1:0]} + {1'b0, nbytes_s}) > 5'd4;
    case (bus.req_size)
      2'd0:    byte_keep_s = 8'h01;
      2'd1:    byte_keep_s = 8'h03;
      2'd2:    byte_keep_s = 8'h0F;
      default: byte_keep_s = 8'h00;
    endcase
    lane_mask_s   = byte_keep_s << bus.req_addr[1:0];
    wdata_shift_s = {32'd0, bus.req_wdata} << {bus.req_addr[1:0], 3'b000};
  end

  // RAM port selection: ACC1 works on the following word and the upper half of the lane window
  always_comb begin
    if (state_q == ACC1) begin
      acc_idx_s = idx_q + {{(WORDS_LOG2-1){1'b0}}, 1'b1};
      wr_be_s   = mask_q[7:4];
      wr_word_s = wdata_q[63:32];
    end else begin
      acc_idx_s = idx_q;
      wr_be_s   = mask_q[3:0];
      wr_word_s = wdata_q[31:0];
    end
    wr_en_s   = we_q && ((state_q == ACC0) || (state_q == ACC1));
    rd_word_s = ram_q[acc_idx_s];
  end

  // RAM write: only enabled lanes of the current word change
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      for (int i = 0; i < 4; i++) begin
        if (wr_be_s[i]) begin
          ram_q[acc_idx_s][8*i +: 8] <= wr_word_s[8*i +: 8];
        end
      end
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept_s) begin
          state_d = req_fault_s ? RESP : ACC0;
        end else begin
          state_d = IDLE;
        end
      end
      ACC0: begin
        state_d = split_q ? ACC1 : RESP;
      end
      ACC1: begin
        state_d = RESP;
      end
      RESP: begin
        if (bus.rsp_ready) begin
          state_d = IDLE;
        end else begin
          state_d = RESP;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // FSM outputs: channel flags decoded from state, payload straight from registers
  always_comb begin
    bus.req_ready = (state_q == IDLE);
    bus.rsp_valid = (state_q == RESP);
    bus.rsp_rdata = rdata_q;
    bus.rsp_fault = fault_q;
  end

  // Datapath next values: capture on accept, gather load bytes during ACC0/ACC1
  always_comb begin
    idx_d   = idx_q;
    off_d   = off_q;
    size_d  = size_q;
    we_d    = we_q;
    split_d = split_q;
    mask_d  = mask_q;
    wdata_d = wdata_q;
    lo_d    = lo_q;
    rdata_d = rdata_q;
    fault_d = fault_q;
    case (state_q)
      IDLE: begin
        if (accept_s) begin
          idx_d   = off33_s[WORDS_LOG2+1:2];
          off_d   = bus.req_addr[1:0];
          size_d  = bus.req_size;
          we_d    = bus.req_we;
          split_d = req_split_s;
          mask_d  = lane_mask_s;
          wdata_d = wdata_shift_s;
          lo_d    = 32'd0;
          rdata_d = 32'd0;
          fault_d = req_fault_s;
        end else begin
          fault_d = fault_q;
        end
      end
      ACC0: begin
        lo_d = rd_word_s;
        if (!split_q && !we_q) begin
          rdata_d = assemble({32'd0, rd_word_s}, off_q, size_q);
        end else begin
          rdata_d = 32'd0;
        end
      end
      ACC1: begin
        if (!we_q) begin
          rdata_d = assemble({rd_word_s, lo_q}, off_q, size_q);
        end else begin
          rdata_d = 32'd0;
        end
      end
      RESP: begin
        rdata_d = rdata_q;
        fault_d = fault_q;
      end
      default: begin
        rdata_d = 32'd0;
        fault_d = 1'b0;
      end
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q   <= '0;
      off_q   <= 2'd0;
      size_q  <= 2'd0;
      we_q    <= 1'b0;
      split_q <= 1'b0;
      mask_q  <= 8'd0;
      wdata_q <= 64'd0;
      lo_q    <= 32'd0;
      rdata_q <= 32'd0;
      fault_q <= 1'b0;
    end else begin
      idx_q   <= idx_d;
      off_q   <= off_d;
      size_q  <= size_d;
      we_q    <= we_d;
      split_q <= split_d;
      mask_q  <= mask_d;
      wdata_q <= wdata_d;
      lo_q    <= lo_d;
      rdata_q <= rdata_d;
      fault_q <= fault_d;
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: a vector table of single requests with
// hand-computed data/fault/latency, plus sequences for response back-pressure and
// reset in the middle of a split store.
module tb_data_mem_responder;

  logic clk = 1'b0;
  logic rst_n;

  data_mem_if bus();

  data_mem_responder dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    string       name;
    logic [31:0] addr;
    logic        we;
    logic [1:0]  size;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_fault;
    int          exp_lat;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // One complete request: wait for accept, count cycles to rsp_valid, then handshake.
  task automatic do_req(input string name, input logic [31:0] addr, input logic we,
                        input logic [1:0] size, input logic [31:0] wdata,
                        output logic [31:0] rdata, output logic fault, output int lat);
    int waitc;
    waitc = 0;
    bus.req_addr  = addr;
    bus.req_we    = we;
    bus.req_size  = size;
    bus.req_wdata = wdata;
    bus.req_valid = 1'b1;
    while (!bus.req_ready && waitc < 50) begin
      @(posedge clk); #1;
      waitc++;
    end
    chk({name, "_ready"}, {31'd0, bus.req_ready}, 32'd1);
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    lat = 1;
    while (!bus.rsp_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    rdata = bus.rsp_rdata;
    fault = bus.rsp_fault;
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
    chk({name, "_vdrop"}, {31'd0, bus.rsp_valid}, 32'd0);
    chk({name, "_rdy_back"}, {31'd0, bus.req_ready}, 32'd1);
  endtask

  initial begin
    logic [31:0] rd;
    logic        flt;
    int          lat;

    // name, addr, we, size, wdata, exp_rdata, exp_fault, exp_lat
    vecs.push_back('{"sw_base",    32'h8000_0000, 1'b1, 2'd2, 32'hDEAD_BEEF, 32'h0000_0000, 1'b0, 2});
    vecs.push_back('{"lw_base",    32'h8000_0000, 1'b0, 2'd2, 32'h0,         32'hDEAD_BEEF, 1'b0, 2});
    vecs.push_back('{"sb_b1",      32'h8000_0001, 1'b1, 2'd0, 32'h0000_0055, 32'h0000_0000, 1'b0, 2});
    vecs.push_back('{"lw_after_sb",32'h8000_0000, 1'b0, 2'd2, 32'h0,         32'hDEAD_55EF, 1'b0, 2});
    vecs.push_back('{"lbu_b3",     32'h8000_0003, 1'b0, 2'd0, 32'h0,         32'h0000_00DE, 1'b0, 2});
    vecs.push_back('{"clr_w0",     32'h8000_0000, 1'b1, 2'd2, 32'h0,         32'h0000_0000, 1'b0, 2});
    vecs.push_back('{"clr_w1",     32'h8000_0004, 1'b1, 2'd2, 32'h0,         32'h0000_0000, 1'b0, 2});
    vecs.push_back('{"clr_w2",     32'h8000_0008, 1'b1, 2'd2, 32'h0,         32'h0000_0000, 1'b0, 2});
    vecs.push_back('{"sh_split",   32'h8000_0003, 1'b1, 2'd1, 32'h0000_A1B2, 32'h0000_0000, 1'b0, 3});
    vecs.push_back('{"lw_w0",      32'h8000_0000, 1'b0, 2'd2, 32'h0,         32'hB200_0000, 1'b0, 2});
    vecs.push_back('{"lw_w1",      32'h8000_0004, 1'b0, 2'd2, 32'h0,         32'h0000_00A1, 1'b0, 2});
    vecs.push_back('{"lhu_split",  32'h8000_0003, 1'b0, 2'd1, 32'h0,         32'h0000_A1B2, 1'b0, 3});
    vecs.push_back('{"sw_last",    32'h807F_FFFC, 1'b1, 2'd2, 32'h1234_5678, 32'h0000_0000, 1'b0, 2});
    vecs.push_back('{"lw_below",   32'h7FFF_FFFC, 1'b0, 2'd2, 32'h0,         32'h0000_0000, 1'b1, 1});
    vecs.push_back('{"sw_over",    32'h807F_FFFE, 1'b1, 2'd2, 32'hCAFE_F00D, 32'h0000_0000, 1'b1, 1});
    vecs.push_back('{"sb_size3",   32'h807F_FFFC, 1'b1, 2'd3, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1});
    vecs.push_back('{"lw_last",    32'h807F_FFFC, 1'b0, 2'd2, 32'h0,         32'h1234_5678, 1'b0, 2});
    vecs.push_back('{"lhu_top",    32'h807F_FFFE, 1'b0, 2'd1, 32'h0,         32'h0000_1234, 1'b0, 2});

    bus.req_valid = 1'b0;
    bus.req_addr  = 32'd0;
    bus.req_we    = 1'b0;
    bus.req_size  = 2'd0;
    bus.req_wdata = 32'd0;
    bus.rsp_ready = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
    chk("rst_req_ready", {31'd0, bus.req_ready}, 32'd1);
    chk("rst_rdata",     bus.rsp_rdata,          32'd0);
    chk("rst_fault",     {31'd0, bus.rsp_fault}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < vecs.size(); i++) begin
      do_req(vecs[i].name, vecs[i].addr, vecs[i].we, vecs[i].size, vecs[i].wdata, rd, flt, lat);
      chk({vecs[i].name, "_rdata"}, rd, vecs[i].exp_rdata);
      chk({vecs[i].name, "_fault"}, {31'd0, flt}, {31'd0, vecs[i].exp_fault});
      chk({vecs[i].name, "_lat"}, lat, vecs[i].exp_lat);
    end

    // Back-pressure: response held 5 cycles while another request waits.
    bus.req_addr  = 32'h8000_0000;
    bus.req_we    = 1'b0;
    bus.req_size  = 2'd2;
    bus.req_valid = 1'b1;
    @(posedge clk); #1;
    chk("bp_busy", {31'd0, bus.req_ready}, 32'd0);
    bus.req_addr = 32'h8000_0004;
    @(posedge clk); #1;
    for (int c = 0; c < 5; c++) begin
      chk("bp_valid", {31'd0, bus.rsp_valid}, 32'd1);
      chk("bp_rdata", bus.rsp_rdata, 32'hB200_0000);
      chk("bp_fault", {31'd0, bus.rsp_fault}, 32'd0);
      chk("bp_req_ready", {31'd0, bus.req_ready}, 32'd0);
      @(posedge clk); #1;
    end
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
    chk("bp_vdrop", {31'd0, bus.rsp_valid}, 32'd0);
    chk("bp_ready_rise", {31'd0, bus.req_ready}, 32'd1);
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    chk("bp_pending_acc", {31'd0, bus.req_ready}, 32'd0);
    lat = 1;
    while (!bus.rsp_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("bp_pending_lat", lat, 2);
    chk("bp_pending_rdata", bus.rsp_rdata, 32'h0000_00A1);
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;

    // Reset during ACC1 of a split store: first word written, second untouched.
    bus.req_addr  = 32'h8000_0006;
    bus.req_we    = 1'b1;
    bus.req_size  = 2'd2;
    bus.req_wdata = 32'h1122_3344;
    bus.req_valid = 1'b1;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", {31'd0, bus.rsp_valid}, 32'd0);
    chk("mid_rst_ready", {31'd0, bus.req_ready}, 32'd1);
    chk("mid_rst_rdata", bus.rsp_rdata, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    do_req("post_rst_w1", 32'h8000_0004, 1'b0, 2'd2, 32'h0, rd, flt, lat);
    chk("post_rst_w1_rdata", rd, 32'h3344_00A1);
    chk("post_rst_w1_lat", lat, 2);
    chk("post_rst_w1_fault", {31'd0, flt}, 32'd0);
    do_req("post_rst_w2", 32'h8000_0008, 1'b0, 2'd2, 32'h0, rd, flt, lat);
    chk("post_rst_w2_rdata", rd, 32'h0000_0000);
    chk("post_rst_w2_lat", lat, 2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
